// File: rtl/reg_file_dump_if.sv
// Register-dump output stream: {addr, data} words with valid/ready.
// master = dumper, slave = sink.
interface reg_file_dump_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDRESS_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0]    out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/reg_file_dump.sv
// Walks the register file on read port 1 and streams {addr, data}.
// REG_FILE_DUMP_SKIP_X0_EN: start the walk at x1 instead of x0.
module reg_file_dump #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0]    rd1,
  reg_file_dump_if.master          stream
);

`ifdef REG_FILE_DUMP_SKIP_X0_EN
  localparam logic [ADDRESS_WIDTH-1:0] FIRST = ADDRESS_WIDTH'(1);
`else
  localparam logic [ADDRESS_WIDTH-1:0] FIRST = '0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [ADDRESS_WIDTH-1:0] cnt_n;
  logic                     valid_n;
  logic [ADDRESS_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0]    data_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      stream.out_valid <= 1'b0;
      stream.out_addr  <= '0;
      stream.out_data  <= '0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      stream.out_valid <= valid_n;
      stream.out_addr  <= addr_n;
      stream.out_data  <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = stream.out_valid;
    addr_n  = stream.out_addr;
    data_n  = stream.out_data;
    unique case (1'b1)
      (state == IDLE): begin
        if (start) begin
          cnt_n   = FIRST;
          state_n = READ;
        end
      end
      (state == READ): begin
        data_n  = rd1;
        addr_n  = cnt;
        valid_n = 1'b1;
        state_n = SEND;
      end
      (state == SEND): begin
        if (stream.out_valid && stream.out_ready) begin
          valid_n = 1'b0;
          // compare, not carry: the counter must not wrap mid-dump
          if (cnt == '1) begin
            state_n = DONE;
          end else begin
            cnt_n   = cnt + 1'b1;
            state_n = READ;
          end
        end
      end
      (state == DONE): begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign a1   = cnt;
  assign busy = (state == READ) || (state == SEND);
  assign done = (state == DONE);

endmodule

// File: tb/tb_reg_file_dump.sv
// Bench for reg_file_dump: register file model plus expected-word model.
// Honors REG_FILE_DUMP_SKIP_X0_EN for the first dumped address.
module tb_reg_file_dump;

`ifdef REG_FILE_DUMP_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int N = 32 - FIRST;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  a1;
  logic [31:0] rd1;

  logic [31:0] regs    [32];
  logic [31:0] ref_mem [32];

  int n_cmp = 0;
  int n_err = 0;

  reg_file_dump_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

  reg_file_dump #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .a1     (a1),
    .rd1    (rd1),
    .stream (bus)
  );

  always #5 clk = ~clk;

  assign rd1 = regs[a1];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < 32; i++) begin
      regs[i]    = rnd ? $urandom : (32'hA000_0000 + i);
      ref_mem[i] = regs[i];
    end
  endtask

  task automatic run(input bit bp, input bit hold,
                     input int abort_at, input int wr_at);
    int          idx      = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    bit          stalled  = 0;
    bit          fin      = 0;
    logic [4:0]  h_addr   = '0;
    logic [31:0] h_data   = '0;
    start = 1'b1;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) start = 1'b0;
      chk("busy_done_excl", busy & done, 1'b0);
      if (cyc == 1) begin
        chk("start_busy", busy, 1'b1);
        chk("start_a1", a1, FIRST);
        chk("start_valid", bus.out_valid, 1'b0);
      end
      if (cyc == 2) chk("first_valid", bus.out_valid, 1'b1);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        fin   = 1;
        start = 1'b0;
      end else if (bus.out_valid) begin
        if (stalled) begin
          chk("stall_addr", bus.out_addr, h_addr);
          chk("stall_data", bus.out_data, h_data);
        end else begin
          chk("word_addr", bus.out_addr, FIRST + idx);
          chk("word_data", bus.out_data, ref_mem[FIRST + idx]);
        end
        h_addr = bus.out_addr;
        h_data = bus.out_data;
        if (int'(bus.out_addr) == abort_at) begin
          bus.out_ready = 1'b0;
          start = 1'b0;
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          chk("abort_valid", bus.out_valid, 1'b0);
          chk("abort_addr", bus.out_addr, 5'd0);
          chk("abort_data", bus.out_data, 32'd0);
          chk("abort_a1", a1, 5'd0);
          chk("abort_busy", busy, 1'b0);
          repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
            chk("abort_idle", busy, 1'b0);
          end
          return;
        end
        if (int'(bus.out_addr) == wr_at && !stalled) begin
          regs[20]    = 32'hDEAD_BEEF;
          ref_mem[20] = 32'hDEAD_BEEF;
        end
        bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = !bus.out_ready;
        if (bus.out_ready) idx++;
      end else begin
        bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    chk("dump_words", idx, N);
    chk("done_pulses", done_cnt, 1);
    if (!bp) chk("busy_cycles", busy_cnt, 2 * N);
    repeat (4) begin
      @(negedge clk);
      chk("after_busy", busy, 1'b0);
      chk("after_done", done, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.out_ready = 1'b0;
    fill(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_addr", bus.out_addr, 5'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_a1", a1, 5'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 1'b0, -1, -1);
    run(1'b1, 1'b0, -1, -1);
    fill(1'b1);
    run(1'b1, 1'b1, -1, -1);
    run(1'b1, 1'b0, 10, -1);
    run(1'b0, 1'b0, -1, -1);
    fill(1'b1);
    run(1'b0, 1'b0, -1, 5);
    chk("wr20_model", ref_mem[20], 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_dump.md
# reg_file_dump

Sequential reader for the RISC-V integer register file. On a start pulse it walks every register address on the file's first read port (`a1`/`rd1`), captures each value and streams it out as {address, data} words over a valid/ready handshake. It sits beside the core's register file and feeds debug, trace and self-check logic. It reads only: it never drives `we3`, `a3` or `wd3`.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 5, register address width; the file has 2^ADDRESS_WIDTH entries.
- `DATA_WIDTH`, 32, register data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  dump request; sampled only in IDLE.
- `busy`  out  1  high in READ and SEND.
- `done`  out  1  one-cycle pulse after the last word transfers.
- `a1`  out  ADDRESS_WIDTH  read address to the register file's first read port.
- `rd1`  in  DATA_WIDTH  combinational read data from the register file.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  stream sink ready.
- `out_addr`  out  ADDRESS_WIDTH  register index of the current word.
- `out_data`  out  DATA_WIDTH  register value of the current word.

## Operation
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `a1`=0. The FSM is in IDLE.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: if `start`=1, load the address counter with FIRST (0, or 1 with the configuration macro) and go to READ. Otherwise stay in IDLE.
- READ: `a1` is driven from the counter, which is registered. At the edge:
  - capture `rd1` into `out_data` and the counter into `out_addr`;
  - set `out_valid`=1;
  - go to SEND.
- SEND: `out_valid`, `out_addr` and `out_data` hold stable until `out_valid && out_ready` at an edge (a transfer). On transfer:
  - clear `out_valid`;
  - if the counter equals all-ones, go to DONE;
  - otherwise increment the counter and go to READ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- The last address is detected by compare, not by carry-out, so the counter never wraps back to 0 inside a dump.
- `start` is ignored in READ, SEND and DONE. There is no queuing and no restart.
- Each value is a snapshot taken at its READ edge. A register-file write to the same address on that same edge is not guaranteed to be seen. Writes to addresses not yet read are seen.
- Reset asserted in any state aborts the dump: the FSM returns to IDLE with the reset values above, and no `done` pulse is issued.
- `out_ready` is don't-care while `out_valid`=0.

## Timing
- `start` is sampled high at edge k. Then:
  - `busy`=1 and `a1`=FIRST from k+1;
  - first `out_valid`=1 from k+2.
- Each word costs one READ cycle plus at least one SEND cycle. With `out_ready` held at 1, a word is presented every 2 cycles.
- Full dump with `out_ready`=1 and ADDRESS_WIDTH=5: 32 words over 64 busy cycles. `done` goes high on the cycle after the last transfer.
- `busy` drops when the FSM enters DONE, so `busy` and `done` are never high together.
- Backpressure stretches SEND indefinitely. `out_*` must not change while `out_valid`=1 and `out_ready`=0.

## Configuration
- `REG_FILE_DUMP_SKIP_X0_EN`:
  - Defined: FIRST=1. Register x0 (hardwired zero) is skipped, and a dump has 2^ADDRESS_WIDTH−1 words (31 at the default).
  - Undefined: FIRST=0, and a dump has 2^ADDRESS_WIDTH words (32 at the default), including x0.

## Test plan
- Full dump: register file preloaded so that reg[i]=0xA000_0000+i, `out_ready`=1, `start` pulsed → 32 transfers, addr 0..31, data 0xA000_0000..0xA000_001F, one per 2 cycles; `done` pulses once; `busy` is low afterwards.
- Backpressure: `out_ready` toggled pseudo-randomly → the same 32 words in order; `out_addr`/`out_data` stable through every stalled SEND cycle.
- `start` held high for the whole dump → exactly one dump; a second dump starts only if `start` is still high when the FSM returns to IDLE.
- Reset pulled low in SEND at address 10 → outputs at reset values on the next cycle; no `done`; a new `start` dumps from address 0 again.
- `REG_FILE_DUMP_SKIP_X0_EN` defined → 31 words, addr 1..31, first data 0xA000_0001.
- Write reg[20]=0xDEAD_BEEF while the dump is at address 5 → the word for address 20 carries 0xDEAD_BEEF.
